// File: rtl/edge_pixel_sink.sv
// rtl/edge_pixel_sink.sv - raster regeneration and magnitude/threshold sink for the filtered pixel stream
//
// Purpose:
//    Consumes the filtered grayscale stream (valid strobe plus signed data,
//    no coordinates). It rebuilds X/Y raster coordinates and frame markers,
//    converts each pixel to pass-through, magnitude or thresholded form and
//    presents an RGB triplet with X/Y to the frame-buffer write path. It also
//    flags short and overlong frames.
//
// Ports:
//    iCLK     system clock, rising edge
//    iRST     asynchronous active-low reset
//    iFVAL    frame valid; rising edge marks frame start
//    iDVAL    pixel beat strobe, one pixel per cycle
//    iDATA    signed two's-complement filtered pixel
//    iMODE    00 pass, 01 absolute, 10 threshold, 11 inverted threshold
//    iTHRESH  unsigned threshold for modes 10/11
//    oDVAL    output pixel valid (2 cycles after accepted beat)
//    oRed     red channel
//    oGreen   green channel
//    oBlue    blue channel
//    oX       column of output pixel
//    oY       line of output pixel
//    oSOF     high with pixel (0,0)
//    oEOF     high with pixel (WIDTH-1,HEIGHT-1)
//    oERR     one-cycle pulse on short or overlong frame

module edge_pixel_sink #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DW     = 12
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iFVAL,
   input  logic          iDVAL,
   input  logic [DW-1:0] iDATA,
   input  logic [1:0]    iMODE,
   input  logic [DW-1:0] iTHRESH,
   output logic          oDVAL,
   output logic [DW-1:0] oRed,
   output logic [DW-1:0] oGreen,
   output logic [DW-1:0] oBlue,
   output logic [9:0]    oX,
   output logic [9:0]    oY,
   output logic          oSOF,
   output logic          oEOF,
   output logic          oERR
);

   localparam logic [9:0]    X_LAST   = 10'(WIDTH - 1);
   localparam logic [9:0]    Y_LAST   = 10'(HEIGHT - 1);
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

   // FRAME_DONE: the EOF pixel has been accepted; further beats before the
   // next frame start are overlong and dropped.
   typedef enum logic {
      FRAME_OPEN,
      FRAME_DONE
   } frame_state_e;

   // Input side / raster state
   logic          fval_q, fval_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   frame_state_e  state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [DW-1:0] thresh_q, thresh_d;

   // Stage 1
   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_data_q, s1_data_d;
   logic [DW-1:0] s1_mag_q, s1_mag_d;
   logic [9:0]    s1_x_q, s1_x_d;
   logic [9:0]    s1_y_q, s1_y_d;
   logic          s1_sof_q, s1_sof_d;
   logic          s1_eof_q, s1_eof_d;
   logic          s1_err_q, s1_err_d;
   logic [1:0]    s1_mode_q, s1_mode_d;
   logic [DW-1:0] s1_thresh_q, s1_thresh_d;

   // Stage 2 (output registers)
   logic          dval_q, dval_d;
   logic [DW-1:0] pix_q, pix_d;
   logic [9:0]    x_out_q, x_out_d;
   logic [9:0]    y_out_q, y_out_d;
   logic          sof_q, sof_d;
   logic          eof_q, eof_d;
   logic          err_q, err_d;

   // Combinational helpers
   logic          frame_rise;
   logic          beat;
   logic [9:0]    cur_x;
   logic [9:0]    cur_y;
   logic          at_origin;
   logic          at_last;
   logic [DW-1:0] mag;
   logic          hit;

   // Absolute value; the most negative code has no positive twin and
   // saturates to the largest positive value.
   always_comb begin
      mag = iDATA;
      if (iDATA == MOST_NEG) begin
         mag = MOST_POS;
      end else if (iDATA[DW-1]) begin
         mag = -iDATA;
      end
   end

   always_comb begin : stage1_comb
      fval_d     = iFVAL;
      frame_rise = iFVAL & ~fval_q;
      beat       = iFVAL & iDVAL;

      // A frame start zeroes the raster before this cycle's beat is placed.
      cur_x   = frame_rise ? 10'd0 : x_q;
      cur_y   = frame_rise ? 10'd0 : y_q;
      state_d = frame_rise ? FRAME_OPEN : state_q;
      x_d     = cur_x;
      y_d     = cur_y;

      at_origin = (cur_x == 10'd0) && (cur_y == 10'd0);
      at_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);

      mode_d   = mode_q;
      thresh_d = thresh_q;

      s1_valid_d  = 1'b0;
      s1_data_d   = s1_data_q;
      s1_mag_d    = s1_mag_q;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;
      s1_sof_d    = 1'b0;
      s1_eof_d    = 1'b0;
      s1_mode_d   = s1_mode_q;
      s1_thresh_d = s1_thresh_q;

      // Counters away from origin at a frame start: previous frame was short.
      s1_err_d = frame_rise && ((x_q != 10'd0) || (y_q != 10'd0));

      if (beat) begin
         if (state_d == FRAME_DONE) begin
            s1_err_d = 1'b1;
         end else begin
            s1_valid_d = 1'b1;
            s1_data_d  = iDATA;
            s1_mag_d   = mag;
            s1_x_d     = cur_x;
            s1_y_d     = cur_y;
            s1_sof_d   = at_origin;
            s1_eof_d   = at_last;

            // Pixel (0,0) already uses the freshly sampled mode/threshold.
            if (at_origin) begin
               mode_d   = iMODE;
               thresh_d = iTHRESH;
            end
            s1_mode_d   = at_origin ? iMODE : mode_q;
            s1_thresh_d = at_origin ? iTHRESH : thresh_q;

            if (at_last) begin
               x_d     = 10'd0;
               y_d     = 10'd0;
               state_d = FRAME_DONE;
            end else if (cur_x == X_LAST) begin
               x_d = 10'd0;
               y_d = cur_y + 10'd1;
            end else begin
               x_d = cur_x + 10'd1;
            end
         end
      end
   end

   always_comb begin : stage2_comb
      hit     = (s1_mag_q >= s1_thresh_q);
      dval_d  = s1_valid_q;
      sof_d   = s1_valid_q & s1_sof_q;
      eof_d   = s1_valid_q & s1_eof_q;
      err_d   = s1_err_q;
      pix_d   = pix_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;

      if (s1_valid_q) begin
         x_out_d = s1_x_q;
         y_out_d = s1_y_q;
         case (s1_mode_q)
            2'b00:   pix_d = s1_data_q;
            2'b01:   pix_d = s1_mag_q;
            2'b10:   pix_d = hit ? ALL_ONES : '0;
            default: pix_d = hit ? '0 : ALL_ONES;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         fval_q      <= 1'b0;
         x_q         <= 10'd0;
         y_q         <= 10'd0;
         state_q     <= FRAME_OPEN;
         mode_q      <= 2'b00;
         thresh_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_mag_q    <= '0;
         s1_x_q      <= 10'd0;
         s1_y_q      <= 10'd0;
         s1_sof_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         s1_mode_q   <= 2'b00;
         s1_thresh_q <= '0;
         dval_q      <= 1'b0;
         pix_q       <= '0;
         x_out_q     <= 10'd0;
         y_out_q     <= 10'd0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         fval_q      <= fval_d;
         x_q         <= x_d;
         y_q         <= y_d;
         state_q     <= state_d;
         mode_q      <= mode_d;
         thresh_q    <= thresh_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_mag_q    <= s1_mag_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_sof_q    <= s1_sof_d;
         s1_eof_q    <= s1_eof_d;
         s1_err_q    <= s1_err_d;
         s1_mode_q   <= s1_mode_d;
         s1_thresh_q <= s1_thresh_d;
         dval_q      <= dval_d;
         pix_q       <= pix_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         err_q       <= err_d;
      end
   end

   // All three channels carry the same grayscale-derived value.
   assign oDVAL  = dval_q;
   assign oRed   = pix_q;
   assign oGreen = pix_q;
   assign oBlue  = pix_q;
   assign oX     = x_out_q;
   assign oY     = y_out_q;
   assign oSOF   = sof_q;
   assign oEOF   = eof_q;
   assign oERR   = err_q;

endmodule

// File: tb/tb_edge_pixel_sink.sv
// tb/tb_edge_pixel_sink.sv - directed self-checking bench for edge_pixel_sink

module tb_edge_pixel_sink;

   localparam int W = 8;
   localparam int H = 4;
   localparam int N = W * H;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iFVAL = 1'b0;
   logic        iDVAL = 1'b0;
   logic [11:0] iDATA = 12'h000;
   logic [1:0]  iMODE = 2'b00;
   logic [11:0] iTHRESH = 12'h000;
   logic        oDVAL;
   logic [11:0] oRed;
   logic [11:0] oGreen;
   logic [11:0] oBlue;
   logic [9:0]  oX;
   logic [9:0]  oY;
   logic        oSOF;
   logic        oEOF;
   logic        oERR;

   logic [11:0] dat [64];
   logic [11:0] exp_pix [64];
   int checks = 0;
   int failures = 0;

   edge_pixel_sink #(.WIDTH(W), .HEIGHT(H), .DW(12)) dut (
      .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
      .iMODE(iMODE), .iTHRESH(iTHRESH), .oDVAL(oDVAL), .oRed(oRed),
      .oGreen(oGreen), .oBlue(oBlue), .oX(oX), .oY(oY), .oSOF(oSOF),
      .oEOF(oEOF), .oERR(oERR)
   );

   always #5 iCLK = ~iCLK;

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n, input logic fval, input logic dval);
      for (int k = 0; k < n; k++) begin
         iFVAL = fval;
         iDVAL = dval;
         iDATA = 12'h123;
         tick();
         chk("idle_dval", 32'(oDVAL), 32'd0);
      end
   endtask

   // Presents n back-to-back beats from dat[], then one gap cycle with iFVAL
   // still high. Each beat's output is checked one step later (2-cycle latency).
   task automatic run_beats(input string tag, input int n, input int x0, input int y0, input logic err0);
      int x;
      int y;
      x = x0;
      y = y0;
      for (int i = 0; i <= n; i++) begin
         iFVAL = 1'b1;
         iDVAL = (i < n);
         iDATA = (i < n) ? dat[i] : 12'h000;
         tick();
         if (i == 0) begin
            chk({tag, "_lat_dval"}, 32'(oDVAL), 32'd0);
            chk({tag, "_lat_err"}, 32'(oERR), 32'd0);
         end else begin
            chk({tag, "_dval"}, 32'(oDVAL), 32'd1);
            chk({tag, "_red"}, 32'(oRed), 32'(exp_pix[i-1]));
            chk({tag, "_green"}, 32'(oGreen), 32'(exp_pix[i-1]));
            chk({tag, "_blue"}, 32'(oBlue), 32'(exp_pix[i-1]));
            chk({tag, "_x"}, 32'(oX), 32'(x));
            chk({tag, "_y"}, 32'(oY), 32'(y));
            chk({tag, "_sof"}, 32'(oSOF), 32'((x == 0) && (y == 0)));
            chk({tag, "_eof"}, 32'(oEOF), 32'((x == W-1) && (y == H-1)));
            chk({tag, "_err"}, 32'(oERR), 32'((i == 1) ? err0 : 1'b0));
            x++;
            if (x == W) begin
               x = 0;
               y++;
               if (y == H) y = 0;
            end
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_dval", 32'(oDVAL), 32'd0);
      chk("rst_red", 32'(oRed), 32'd0);
      chk("rst_x", 32'(oX), 32'd0);
      chk("rst_y", 32'(oY), 32'd0);
      chk("rst_sof", 32'(oSOF), 32'd0);
      chk("rst_eof", 32'(oEOF), 32'd0);
      chk("rst_err", 32'(oERR), 32'd0);
      iRST = 1'b1;
      idle(2, 1'b0, 1'b0);

      // Full frame, magnitude of -5
      iMODE = 2'b01;
      iTHRESH = 12'd0;
      for (int i = 0; i < N; i++) begin dat[i] = 12'hFFB; exp_pix[i] = 12'h005; end
      run_beats("f1", N, 0, 0, 1'b0);
      idle(1, 1'b0, 1'b0);
      chk("hold_x", 32'(oX), 32'd7);
      chk("hold_y", 32'(oY), 32'd3);
      chk("hold_red", 32'(oRed), 32'h005);
      chk("hold_err", 32'(oERR), 32'd0);

      // Beats without frame valid are dropped and leave the raster alone
      idle(5, 1'b0, 1'b1);
      chk("gate_x", 32'(oX), 32'd7);
      chk("gate_err", 32'(oERR), 32'd0);

      // Magnitude saturation
      for (int i = 0; i < N; i++) begin dat[i] = 12'(i); exp_pix[i] = 12'(i); end
      dat[0] = 12'h800; exp_pix[0] = 12'h7FF;
      dat[1] = 12'h7FF; exp_pix[1] = 12'h7FF;
      dat[2] = 12'hFFF; exp_pix[2] = 12'h001;
      run_beats("sat", N, 0, 0, 1'b0);
      idle(1, 1'b0, 1'b0);

      // Pass-through keeps raw bits
      iMODE = 2'b00;
      for (int i = 0; i < N; i++) begin dat[i] = 12'(i); exp_pix[i] = 12'(i); end
      dat[0] = 12'h800; exp_pix[0] = 12'h800;
      dat[1] = 12'hFFB; exp_pix[1] = 12'hFFB;
      run_beats("pass", N, 0, 0, 1'b0);
      idle(1, 1'b0, 1'b0);

      // Threshold 100 with 99/100/-100/-99; mode/threshold change mid-frame ignored
      iMODE = 2'b10;
      iTHRESH = 12'd100;
      for (int i = 0; i < N; i++) begin
         case (i % 4)
            0: begin dat[i] = 12'd99;  exp_pix[i] = 12'h000; end
            1: begin dat[i] = 12'd100; exp_pix[i] = 12'hFFF; end
            2: begin dat[i] = 12'hF9C; exp_pix[i] = 12'hFFF; end
            default: begin dat[i] = 12'hF9D; exp_pix[i] = 12'h000; end
         endcase
      end
      run_beats("thr_a", 4, 0, 0, 1'b0);
      iMODE = 2'b11;
      iTHRESH = 12'd5;
      run_beats("thr_b", N - 4, 4, 0, 1'b0);
      idle(1, 1'b0, 1'b0);

      // Inverted threshold takes effect at next frame's first pixel
      iTHRESH = 12'd100;
      for (int i = 0; i < N; i++) exp_pix[i] = ~exp_pix[i];
      run_beats("inv", N, 0, 0, 1'b0);
      idle(1, 1'b0, 1'b0);

      // Short frame then a new frame with a beat on the rising edge
      iMODE = 2'b01;
      for (int i = 0; i < N; i++) begin dat[i] = 12'(i); exp_pix[i] = 12'(i); end
      run_beats("short", 10, 0, 0, 1'b0);
      idle(1, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin dat[i] = 12'd3; exp_pix[i] = 12'd3; end
      run_beats("after_short", N, 0, 0, 1'b1);
      idle(1, 1'b0, 1'b0);

      // Overlong frame: two extra beats, each an error pulse, no output
      for (int i = 0; i < N; i++) begin dat[i] = 12'hFF0; exp_pix[i] = 12'h010; end
      run_beats("ovl", N, 0, 0, 1'b0);
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      iDATA = 12'h055;
      tick();
      chk("ovl_dval0", 32'(oDVAL), 32'd0);
      chk("ovl_err0", 32'(oERR), 32'd0);
      tick();
      chk("ovl_dval1", 32'(oDVAL), 32'd0);
      chk("ovl_err1", 32'(oERR), 32'd1);
      iDVAL = 1'b0;
      tick();
      chk("ovl_dval2", 32'(oDVAL), 32'd0);
      chk("ovl_err2", 32'(oERR), 32'd1);
      tick();
      chk("ovl_err3", 32'(oERR), 32'd0);
      chk("ovl_x", 32'(oX), 32'd7);
      chk("ovl_y", 32'(oY), 32'd3);
      idle(1, 1'b0, 1'b0);

      // Reset mid-frame with a beat in flight
      for (int i = 0; i < N; i++) begin dat[i] = 12'd7; exp_pix[i] = 12'd7; end
      run_beats("pre_rst", 10, 0, 0, 1'b0);
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      iDATA = 12'd7;
      tick();
      iRST = 1'b0;
      #1;
      chk("mr_dval", 32'(oDVAL), 32'd0);
      chk("mr_red", 32'(oRed), 32'd0);
      chk("mr_x", 32'(oX), 32'd0);
      chk("mr_y", 32'(oY), 32'd0);
      chk("mr_err", 32'(oERR), 32'd0);
      tick();
      chk("mr_dval_hold", 32'(oDVAL), 32'd0);
      tick();
      iRST = 1'b1;
      run_beats("post_rst", N, 0, 0, 1'b0);
      idle(2, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
